// File: rtl/pad_input_filter.sv
// Input conditioning for one pad: synchronizes the raw pad level, rejects glitches
// shorter than a programmable length, and reports accepted edges as pulses and sticky flags.
module pad_input_filter #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_WIDTH   = 8,
    parameter logic        RST_VAL     = 1'b0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 pad_i,
    input  logic                 en_i,
    input  logic [CNT_WIDTH-1:0] filt_len_i,
    input  logic                 clr_i,
    output logic                 level_o,
    output logic                 rise_o,
    output logic                 fall_o,
    output logic                 rise_evt_o,
    output logic                 fall_evt_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic                   differ;
    logic                   accept;

    // Synchronizer keeps running while the filter is disabled so re-enabling sees a settled value.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i};
        end
    end

    assign sync   = sync_q[SYNC_STAGES-1];
    assign differ = (sync != level_o);
    // The >= compare lets a shortened filter length take effect at once without overflow.
    assign accept = en_i && differ && (cnt_q >= filt_len_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (!en_i || !differ || accept) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            level_o <= RST_VAL;
            rise_o  <= 1'b0;
            fall_o  <= 1'b0;
        end else begin
            rise_o <= accept && sync;
            fall_o <= accept && !sync;
            if (accept) begin
                level_o <= sync;
            end
        end
    end

    // Flags set on the accepting edge and again while the pulse is visible, so a clear
    // that coincides with either loses to the new edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rise_evt_o <= 1'b0;
            fall_evt_o <= 1'b0;
        end else begin
            rise_evt_o <= (accept && sync)  || rise_o || (rise_evt_o && !clr_i);
            fall_evt_o <= (accept && !sync) || fall_o || (fall_evt_o && !clr_i);
        end
    end

endmodule

// File: tb/tb_pad_input_filter.sv
// Scoreboard bench for pad_input_filter: a cycle model pushes expected outputs at each
// clock edge, and they are popped and compared against the DUT on the following falling edge.
module tb_pad_input_filter;

    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned CNT_WIDTH   = 8;
    localparam logic        RST_VAL     = 1'b0;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 pad;
    logic                 en;
    logic                 clr;
    logic [CNT_WIDTH-1:0] filt_len;
    logic                 level, rise, fall, rise_evt, fall_evt;

    pad_input_filter #(
        .SYNC_STAGES(SYNC_STAGES),
        .CNT_WIDTH  (CNT_WIDTH),
        .RST_VAL    (RST_VAL)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .pad_i     (pad),
        .en_i      (en),
        .filt_len_i(filt_len),
        .clr_i     (clr),
        .level_o   (level),
        .rise_o    (rise),
        .fall_o    (fall),
        .rise_evt_o(rise_evt),
        .fall_evt_o(fall_evt)
    );

    always #5 clk = ~clk;

    logic [4:0] sb[$];
    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic m_pipe[SYNC_STAGES];
    logic m_level, m_rise, m_fall, m_rise_evt, m_fall_evt;
    int   m_run;

    // Per-scenario observations
    int cyc, rise_cyc, fall_cyc, n_rise, n_fall;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < int'(SYNC_STAGES); i++) m_pipe[i] = RST_VAL;
        m_level    = RST_VAL;
        m_rise     = 1'b0;
        m_fall     = 1'b0;
        m_rise_evt = 1'b0;
        m_fall_evt = 1'b0;
        m_run      = 0;
    endtask

    task automatic model_step();
        logic s, nr, nf, pr, pf;
        s  = m_pipe[SYNC_STAGES-1];
        pr = m_rise;
        pf = m_fall;
        nr = 1'b0;
        nf = 1'b0;
        if (!en || s == m_level) begin
            m_run = 0;
        end else begin
            m_run++;
            if (m_run > int'(filt_len)) begin
                m_level = s;
                nr      = s;
                nf      = !s;
                m_run   = 0;
            end
        end
        m_rise_evt = nr | pr | (m_rise_evt & !clr);
        m_fall_evt = nf | pf | (m_fall_evt & !clr);
        m_rise     = nr;
        m_fall     = nf;
        for (int i = int'(SYNC_STAGES) - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
        m_pipe[0] = pad;
    endtask

    task automatic mark();
        cyc      = 0;
        rise_cyc = -1;
        fall_cyc = -1;
        n_rise   = 0;
        n_fall   = 0;
    endtask

    task automatic tick(input string tag);
        logic [4:0] e;
        @(posedge clk);
        if (rst_n) model_step();
        sb.push_back({m_level, m_rise, m_fall, m_rise_evt, m_fall_evt});
        @(negedge clk);
        e = sb.pop_front();
        checkOutput(tag, 32'({level, rise, fall, rise_evt, fall_evt}), 32'(e));
        cyc++;
        if (rise) begin
            n_rise++;
            if (rise_cyc < 0) rise_cyc = cyc;
        end
        if (fall) begin
            n_fall++;
            if (fall_cyc < 0) fall_cyc = cyc;
        end
    endtask

    task automatic applyStimulus(input logic p, input logic e, input logic c, input int n, input string tag);
        pad = p;
        en  = e;
        clr = c;
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    initial begin
        rst_n    = 1'b0;
        pad      = 1'b0;
        en       = 1'b1;
        clr      = 1'b0;
        filt_len = 8'd3;
        model_reset();
        mark();
        #1;
        checkOutput("reset_initial", 32'({level, rise, fall, rise_evt, fall_evt}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(1'b0, 1'b1, 1'b0, 20, "idle");

        mark();
        applyStimulus(1'b1, 1'b1, 1'b0, 12, "step_rise");
        checkOutput("rise_cycle", rise_cyc, 6);
        checkOutput("rise_count", n_rise, 1);

        mark();
        applyStimulus(1'b0, 1'b1, 1'b0, 12, "step_fall");
        checkOutput("fall_cycle", fall_cyc, 6);

        mark();
        applyStimulus(1'b1, 1'b1, 1'b0, 3, "glitch3");
        applyStimulus(1'b0, 1'b1, 1'b0, 10, "glitch3_after");
        checkOutput("glitch3_no_rise", n_rise, 0);

        mark();
        applyStimulus(1'b1, 1'b1, 1'b0, 4, "pulse4");
        applyStimulus(1'b0, 1'b1, 1'b0, 12, "pulse4_after");
        checkOutput("pulse4_rise", n_rise, 1);
        checkOutput("pulse4_fall", n_fall, 1);

        filt_len = 8'd0;
        mark();
        for (int i = 0; i < 8; i++) applyStimulus(logic'(i % 2 == 0), 1'b1, 1'b0, 2, "toggle");
        applyStimulus(1'b0, 1'b1, 1'b0, 6, "toggle_hold");
        checkOutput("toggle_latency", rise_cyc, 3);
        checkOutput("toggle_rises", n_rise, 4);
        checkOutput("toggle_falls", n_fall, 4);

        filt_len = 8'd3;
        mark();
        applyStimulus(1'b1, 1'b0, 1'b0, 50, "disabled");
        checkOutput("disabled_no_rise", n_rise, 0);
        mark();
        applyStimulus(1'b1, 1'b1, 1'b0, 10, "enabled");
        checkOutput("enable_latency", rise_cyc, 4);

        applyStimulus(1'b0, 1'b1, 1'b0, 10, "back_low");
        applyStimulus(1'b0, 1'b1, 1'b1, 1, "clr_both");
        applyStimulus(1'b0, 1'b1, 1'b0, 2, "cleared");
        mark();
        applyStimulus(1'b1, 1'b1, 1'b0, 6, "rise_for_clr");
        checkOutput("rise_before_clr", rise_cyc, 6);
        applyStimulus(1'b1, 1'b1, 1'b1, 1, "clr_with_rise");
        checkOutput("evt_kept", rise_evt, 1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1, "clr_alone");
        checkOutput("evt_cleared", rise_evt, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 5, "fall_pending");
        applyStimulus(1'b0, 1'b1, 1'b1, 1, "clr_on_accept");
        checkOutput("fall_evt_set_wins", fall_evt, 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 3, "after_set_wins");

        applyStimulus(1'b1, 1'b1, 1'b0, 10, "high_before_reset");
        applyStimulus(1'b0, 1'b1, 1'b0, 4, "pending_fall");
        rst_n = 1'b0;
        #1;
        checkOutput("reset_midcount", 32'({level, rise, fall, rise_evt, fall_evt}), 32'd0);
        model_reset();
        tick("in_reset");
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b0, 10, "after_reset");

        filt_len = 8'd255;
        mark();
        applyStimulus(1'b1, 1'b1, 1'b0, 262, "filt_max");
        checkOutput("filt_max_latency", rise_cyc, 258);

        mark();
        applyStimulus(1'b0, 1'b1, 1'b0, 20, "long_count");
        filt_len = 8'd2;
        applyStimulus(1'b0, 1'b1, 1'b0, 5, "shortened");
        checkOutput("shortened_accept", fall_cyc, 21);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
